// File: rtl/pio_out_pkg.sv
// Shared definitions for the pio_out_pulse output PIO: register map,
// STATUS bit positions and the pulse engine state type.
package pio_out_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_OUT    = 3'd1;
    localparam logic [2:0] ADDR_PULSE  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLEAR  = 3'd5;
    localparam logic [2:0] ADDR_LEN    = 3'd6;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_OVERRUN = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_e;

    // Addresses whose writes modify data_out and raise data_written.
    function automatic logic isDataAddr(input logic [2:0] addr);
        return (addr == ADDR_DATA) || (addr == ADDR_SET) || (addr == ADDR_CLEAR);
    endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse timer: holds the inversion mask for max(len,1) cycles after a load,
// then clears it. A load is honoured only when idle or in the final cycle.
module pio_pulse_timer
    import pio_out_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_len,
    input  logic [WIDTH-1:0] i_mask,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_mask,
    output logic             o_expire
);

    pulse_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mask;

    logic [CNT_W-1:0] w_firstCnt;
    logic             w_lastCycle;
    logic             w_loadOk;

    // A zero length is treated as one, so the count never underflows.
    assign w_firstCnt  = (i_len == '0) ? '0 : (i_len - CNT_W'(1));
    assign w_lastCycle = (r_state == ACTIVE) && (r_cnt == '0);
    assign w_loadOk    = i_load && ((r_state == IDLE) || w_lastCycle);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_loadOk) begin
                        r_state <= ACTIVE;
                        r_cnt   <= w_firstCnt;
                        r_mask  <= i_mask;
                    end
                end
                ACTIVE: begin
                    if (w_loadOk) begin
                        r_cnt  <= w_firstCnt;
                        r_mask <= i_mask;
                    end else if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_mask  <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_mask  <= '0;
                end
            endcase
        end
    end

    assign o_busy   = (r_state == ACTIVE);
    assign o_mask   = r_mask;
    assign o_expire = w_lastCycle;

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear, a timed inversion pulse engine
// and a STATUS register carrying busy and a sticky overrun flag.
module pio_out_pulse
    import pio_out_pkg::*;
#(
    parameter int               WIDTH             = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE       = WIDTH'(10'h3FF),
    parameter int               CNT_W             = 16,
    parameter int unsigned      PULSE_LEN_DEFAULT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             data_written
);

    logic [WIDTH-1:0] r_dataOut;
    logic [CNT_W-1:0] r_len;
    logic             r_overrun;
    logic             r_dataWritten;

    logic             w_write;
    logic [WIDTH-1:0] w_wd;
    logic             w_pulseWrite;
    logic             w_pulseLoad;
    logic             w_overrunSet;
    logic             w_overrunClr;
    logic             w_busy;
    logic             w_expire;
    logic [WIDTH-1:0] w_mask;
    logic             w_unused;

    assign w_write      = chipselect && !write_n;
    assign w_wd         = writedata[WIDTH-1:0];
    assign w_pulseWrite = w_write && (address == ADDR_PULSE);

    // A PULSE write in the final active cycle restarts seamlessly; earlier ones overrun.
    assign w_pulseLoad  = w_pulseWrite && (w_wd != '0) && (!w_busy || w_expire);
    assign w_overrunSet = w_pulseWrite && w_busy && !w_expire;
    assign w_overrunClr = w_write && (address == ADDR_STATUS) && writedata[STATUS_OVERRUN];

    assign w_unused = &{1'b0, writedata};

    pio_pulse_timer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_pulseLoad),
        .i_len    (r_len),
        .i_mask   (w_wd),
        .o_busy   (w_busy),
        .o_mask   (w_mask),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataOut <= RESET_VALUE;
        end else if (w_write) begin
            case (address)
                ADDR_DATA:  r_dataOut <= w_wd;
                ADDR_SET:   r_dataOut <= r_dataOut | w_wd;
                ADDR_CLEAR: r_dataOut <= r_dataOut & ~w_wd;
                default:    r_dataOut <= r_dataOut;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataWritten <= 1'b0;
        end else begin
            r_dataWritten <= w_write && isDataAddr(address);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len <= CNT_W'(PULSE_LEN_DEFAULT);
        end else if (w_write && (address == ADDR_LEN)) begin
            r_len <= writedata[CNT_W-1:0];
        end
    end

    // Setting wins over a coincident write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_overrunSet) begin
            r_overrun <= 1'b1;
        end else if (w_overrunClr) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_port     = r_dataOut ^ w_mask;
    assign data_written = r_dataWritten;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(r_dataOut);
            ADDR_OUT:    readdata = 32'(out_port);
            ADDR_PULSE:  readdata = 32'(w_mask);
            ADDR_STATUS: begin
                readdata[STATUS_BUSY]    = w_busy;
                readdata[STATUS_OVERRUN] = r_overrun;
            end
            ADDR_LEN:    readdata = 32'(r_len);
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed plus randomized bench for pio_out_pulse, checked against a
// cycle-level model that tracks how many inverted cycles remain.
module tb_pio_out_pulse;

    localparam int WIDTH = 10;
    localparam int CNT_W = 16;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_OUT    = 3'd1;
    localparam logic [2:0] A_PULSE  = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLEAR  = 3'd5;
    localparam logic [2:0] A_LEN    = 3'd6;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             data_written;

    logic [WIDTH-1:0] mData;
    logic [WIDTH-1:0] mMask;
    int               mRemain;
    int               mLen;
    logic             mOverrun;
    logic             mWritten;

    int nChecks = 0;
    int nFail   = 0;

    pio_out_pulse #(
        .WIDTH             (WIDTH),
        .RESET_VALUE       (10'h3FF),
        .CNT_W             (CNT_W),
        .PULSE_LEN_DEFAULT (1000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .out_port     (out_port),
        .data_written (data_written)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [2:0] a);
        case (a)
            A_DATA:   return 32'(mData);
            A_OUT:    return 32'(mData ^ mMask);
            A_PULSE:  return 32'(mMask);
            A_STATUS: return {30'b0, mOverrun, (mRemain > 0)};
            A_LEN:    return 32'(mLen);
            default:  return 32'h0;
        endcase
    endfunction

    // Behaviour at one clock edge, given the bus write presented during that cycle.
    function automatic void modelStep(input logic wr, input logic [2:0] a, input logic [31:0] d);
        logic [WIDTH-1:0] wd;
        logic [WIDTH-1:0] nextMask;
        int               nextRemain;
        logic             ovSet;
        logic             ovClr;
        wd = d[WIDTH-1:0];
        if (reset) begin
            mData    = 10'h3FF;
            mMask    = '0;
            mRemain  = 0;
            mLen     = 1000;
            mOverrun = 1'b0;
            mWritten = 1'b0;
            return;
        end
        mWritten   = wr && (a == A_DATA || a == A_SET || a == A_CLEAR);
        nextRemain = (mRemain > 0) ? mRemain - 1 : 0;
        nextMask   = (nextRemain > 0) ? mMask : '0;
        ovSet      = 1'b0;
        ovClr      = 1'b0;
        if (wr) begin
            case (a)
                A_DATA:   mData = wd;
                A_SET:    mData = mData | wd;
                A_CLEAR:  mData = mData & ~wd;
                A_PULSE: begin
                    if (mRemain > 1) begin
                        ovSet = 1'b1;
                    end else if (wd != '0) begin
                        nextMask   = wd;
                        nextRemain = (mLen == 0) ? 1 : mLen;
                    end
                end
                A_STATUS: ovClr = d[1];
                A_LEN:    mLen = int'(d[CNT_W-1:0]);
                default: ;
            endcase
        end
        if (ovSet) mOverrun = 1'b1;
        else if (ovClr) mOverrun = 1'b0;
        mRemain = nextRemain;
        mMask   = nextMask;
    endfunction

    task automatic applyStimulus(input logic wr, input logic [2:0] a, input logic [31:0] d);
        chipselect = wr;
        write_n    = !wr;
        address    = a;
        writedata  = d;
        @(posedge clk);
        modelStep(wr, a, d);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readConst(input string tag, input logic [2:0] a, input logic [31:0] expected);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        checkOutput(tag, readdata, expected);
        chipselect = 1'b0;
    endtask

    task automatic checkState(input string tag, input logic [2:0] ra);
        checkOutput({tag, ":out_port"}, 32'(out_port), 32'(mData ^ mMask));
        checkOutput({tag, ":data_written"}, 32'(data_written), 32'(mWritten));
        readConst({tag, ":readdata"}, ra, modelRead(ra));
    endtask

    initial begin
        logic        wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] rnd;

        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        mData = '0; mMask = '0; mRemain = 0; mLen = 0; mOverrun = 1'b0; mWritten = 1'b0;

        applyStimulus(1'b0, A_DATA, 32'h0);
        applyStimulus(1'b0, A_DATA, 32'h0);
        reset = 1'b0;
        checkOutput("reset:out_port", 32'(out_port), 32'h3FF);
        checkOutput("reset:data_written", 32'(data_written), 32'h0);
        readConst("reset:data", A_DATA, 32'h3FF);
        readConst("reset:status", A_STATUS, 32'h0);
        readConst("reset:len", A_LEN, 32'd1000);

        applyStimulus(1'b1, A_DATA, 32'hFFFF_F0F0);
        checkOutput("data:out_port", 32'(out_port), 32'h0F0);
        checkOutput("data:data_written", 32'(data_written), 32'h1);
        applyStimulus(1'b1, A_SET, 32'h003);
        checkOutput("set:out_port", 32'(out_port), 32'h0F3);
        checkOutput("set:data_written", 32'(data_written), 32'h1);
        applyStimulus(1'b1, A_CLEAR, 32'h010);
        checkOutput("clear:out_port", 32'(out_port), 32'h0E3);
        checkState("clear", A_DATA);
        applyStimulus(1'b0, A_DATA, 32'h0);
        checkOutput("idle:data_written", 32'(data_written), 32'h0);

        applyStimulus(1'b1, A_LEN, 32'd3);
        applyStimulus(1'b1, A_DATA, 32'h000);
        applyStimulus(1'b1, A_PULSE, 32'h005);
        for (int i = 0; i < 3; i++) begin
            checkOutput("len3:out_port", 32'(out_port), 32'h005);
            readConst("len3:status", A_STATUS, 32'h1);
            applyStimulus(1'b0, A_DATA, 32'h0);
        end
        checkOutput("len3:after", 32'(out_port), 32'h000);
        readConst("len3:status_after", A_STATUS, 32'h0);
        readConst("len3:pulse_after", A_PULSE, 32'h0);

        applyStimulus(1'b1, A_LEN, 32'd0);
        applyStimulus(1'b1, A_PULSE, 32'h200);
        checkOutput("len0:out_port", 32'(out_port), 32'h200);
        applyStimulus(1'b0, A_DATA, 32'h0);
        checkOutput("len0:after", 32'(out_port), 32'h000);

        applyStimulus(1'b1, A_LEN, 32'd5);
        applyStimulus(1'b1, A_PULSE, 32'h001);
        applyStimulus(1'b0, A_DATA, 32'h0);
        applyStimulus(1'b1, A_PULSE, 32'h002);
        checkOutput("overrun:out_port", 32'(out_port), 32'h001);
        readConst("overrun:status", A_STATUS, 32'h3);
        applyStimulus(1'b0, A_DATA, 32'h0);
        applyStimulus(1'b0, A_DATA, 32'h0);
        checkOutput("expiry:out_port", 32'(out_port), 32'h001);
        applyStimulus(1'b1, A_PULSE, 32'h004);
        checkOutput("restart:out_port", 32'(out_port), 32'h004);
        readConst("restart:pulse", A_PULSE, 32'h004);
        applyStimulus(1'b1, A_STATUS, 32'h2);
        readConst("w1c:status", A_STATUS, 32'h1);
        checkState("w1c", A_PULSE);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, A_DATA, 32'h0);
        checkState("drain", A_STATUS);

        applyStimulus(1'b1, A_LEN, 32'd10);
        applyStimulus(1'b1, A_PULSE, 32'h00F);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, A_DATA, 32'h0);
        checkOutput("midpulse:out_port", 32'(out_port), 32'h00F);
        reset = 1'b1;
        applyStimulus(1'b0, A_DATA, 32'h0);
        reset = 1'b0;
        checkOutput("abort:out_port", 32'(out_port), 32'h3FF);
        readConst("abort:status", A_STATUS, 32'h0);
        readConst("abort:len", A_LEN, 32'd1000);
        checkState("abort", A_PULSE);

        for (int i = 0; i < 600; i++) begin
            rnd   = $urandom;
            reset = (rnd[6:0] < 7'd2);
            wr    = ($urandom_range(0, 9) < 7);
            a     = 3'($urandom_range(0, 7));
            d     = $urandom;
            if (a == A_LEN) d[CNT_W-1:0] = CNT_W'($urandom_range(0, 6));
            if (a == A_PULSE && $urandom_range(0, 9) == 0) d[WIDTH-1:0] = '0;
            applyStimulus(wr, a, d);
            reset = 1'b0;
            checkState("random", 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
